// File: rtl/rupt_priority_arbiter.sv
// AGC interrupt (rupt) arbiter: latches rupt source edges as pending, picks the
// highest-priority one, and handshakes RUPTOR_n/KRPT/RELPLS with the sequence generator.
module rupt_priority_arbiter #(
    parameter int unsigned NRUPT      = 10,
    parameter logic [11:0] VEC_BASE   = 12'o4000,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic             GOJAM,
    input  logic [NRUPT-1:0] RUPT_REQ,
    input  logic             INHINT,
    input  logic             EXTPND,
    input  logic             OVNHRP,
    input  logic             MNHRPT,
    input  logic             KRPT,
    input  logic             RELPLS,
    output logic             RUPTOR_n,
    output logic [3:0]       RPT_IDX,
    output logic [11:0]      RPT_VEC,
    output logic             RPT_STB,
    output logic             IIP,
    output logic [NRUPT-1:0] PEND
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned VEC_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [NRUPT-1:0]   req_q;
    logic [NRUPT-1:0]   req_q_d;
    logic [NRUPT-1:0]   req_rise;
    logic [NRUPT-1:0]   sel_mask;
    logic [NRUPT-1:0]   pend_d;
    logic [IDX_W-1:0]   idx_lowest;
    logic [IDX_W-1:0]   idx_d;
    logic               ruptor_n_d;
    logic               stb_d;
    logic               iip_d;
    logic               inhibit;

    assign inhibit  = INHINT | EXTPND | OVNHRP | MNHRPT;
    assign req_rise = RUPT_REQ & ~req_q;
    assign sel_mask = {{(NRUPT-1){1'b0}}, 1'b1} << RPT_IDX;

    // Vector address derives only from the registered index.
    assign RPT_VEC = VEC_BASE + VEC_W'(VEC_STRIDE * (32'(RPT_IDX) + 32'd1));

    // Lowest set pending bit wins; index 0 is the highest priority.
    always_comb begin
        idx_lowest = '0;
        for (int i = int'(NRUPT) - 1; i >= 0; i--) begin
            if (PEND[i]) begin
                idx_lowest = IDX_W'(i);
            end
        end
    end

    // Next state, pending latches and registered outputs.
    always_comb begin
        state_d    = state_q;
        pend_d     = PEND;
        idx_d      = RPT_IDX;
        ruptor_n_d = RUPTOR_n;
        stb_d      = 1'b0;
        iip_d      = IIP;
        req_q_d    = RUPT_REQ;

        if (GOJAM) begin
            state_d    = ST_IDLE;
            pend_d     = '0;
            idx_d      = '0;
            ruptor_n_d = 1'b1;
            iip_d      = 1'b0;
            req_q_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if ((|PEND) && !inhibit) begin
                        idx_d      = idx_lowest;
                        ruptor_n_d = 1'b0;
                        state_d    = ST_REQ;
                    end
                end
                ST_REQ: begin
                    // KRPT outranks a same-cycle inhibit; index stays frozen meanwhile.
                    if (KRPT) begin
                        pend_d     = PEND & ~sel_mask;
                        stb_d      = 1'b1;
                        iip_d      = 1'b1;
                        ruptor_n_d = 1'b1;
                        state_d    = ST_SERVICE;
                    end else if (inhibit) begin
                        ruptor_n_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (RELPLS) begin
                        iip_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    ruptor_n_d = 1'b1;
                    iip_d      = 1'b0;
                end
            endcase
            // A new edge wins over a same-cycle clear.
            pend_d = pend_d | req_rise;
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            PEND     <= '0;
            RPT_IDX  <= '0;
            RUPTOR_n <= 1'b1;
            RPT_STB  <= 1'b0;
            IIP      <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_q_d;
            PEND     <= pend_d;
            RPT_IDX  <= idx_d;
            RUPTOR_n <= ruptor_n_d;
            RPT_STB  <= stb_d;
            IIP      <= iip_d;
        end
    end

endmodule

// File: tb/tb_rupt_priority_arbiter.sv
// Bench for rupt_priority_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the rupt rules.
module tb_rupt_priority_arbiter;

    logic        sim_clk = 1'b0;
    logic        sim_rst = 1'b0;
    logic        gojam = 1'b0;
    logic [9:0]  rupt_req = '0;
    logic        inhint = 1'b0, extpnd = 1'b0, ovnhrp = 1'b0, mnhrpt = 1'b0;
    logic        krpt = 1'b0, relpls = 1'b0;
    logic        ruptor_n;
    logic [3:0]  rpt_idx;
    logic [11:0] rpt_vec;
    logic        rpt_stb;
    logic        iip;
    logic [9:0]  pend;

    int n_tests = 0;
    int n_fail  = 0;

    rupt_priority_arbiter dut (
        .SIM_CLK (sim_clk),
        .SIM_RST (sim_rst),
        .GOJAM   (gojam),
        .RUPT_REQ(rupt_req),
        .INHINT  (inhint),
        .EXTPND  (extpnd),
        .OVNHRP  (ovnhrp),
        .MNHRPT  (mnhrpt),
        .KRPT    (krpt),
        .RELPLS  (relpls),
        .RUPTOR_n(ruptor_n),
        .RPT_IDX (rpt_idx),
        .RPT_VEC (rpt_vec),
        .RPT_STB (rpt_stb),
        .IIP     (iip),
        .PEND    (pend)
    );

    always #5 sim_clk = ~sim_clk;

    // Behavioural model: what the sequencer should see, phase by phase.
    localparam int MODE_IDLE = 0, MODE_ASK = 1, MODE_SERVE = 2;
    bit [9:0] m_pend, m_prev;
    int       m_mode, m_idx;
    bit       m_stb, m_iip;

    function automatic void m_clear();
        m_pend = '0; m_prev = '0; m_mode = MODE_IDLE; m_idx = 0; m_stb = 0; m_iip = 0;
    endfunction

    function automatic int m_lowest(bit [9:0] p);
        for (int i = 0; i < 10; i++) if (p[i]) return i;
        return 0;
    endfunction

    function automatic void model_edge();
        bit       inh = inhint | extpnd | ovnhrp | mnhrpt;
        bit [9:0] rises = rupt_req & ~m_prev;
        bit [9:0] np = m_pend;
        m_stb = 0;
        if (gojam) begin
            m_clear();
            return;
        end
        m_prev = rupt_req;
        if (m_mode == MODE_IDLE) begin
            if (m_pend != 0 && !inh) begin
                m_idx = m_lowest(m_pend);
                m_mode = MODE_ASK;
            end
        end else if (m_mode == MODE_ASK) begin
            if (krpt) begin
                np[m_idx] = 1'b0;
                m_stb = 1; m_iip = 1; m_mode = MODE_SERVE;
            end else if (inh) begin
                m_mode = MODE_IDLE;
            end
        end else if (relpls) begin
            m_iip = 0; m_mode = MODE_IDLE;
        end
        m_pend = np | rises;
    endfunction

    function automatic logic [28:0] model_obs();
        logic [11:0] vec = 12'(32'o4000 + 4 * (m_idx + 1));
        return {m_pend, (m_mode != MODE_ASK), 4'(m_idx), vec, m_stb, m_iip};
    endfunction

    function automatic logic [28:0] dut_obs();
        return {pend, ruptor_n, rpt_idx, rpt_vec, rpt_stb, iip};
    endfunction

    task automatic step();
        model_edge();
        @(posedge sim_clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && !(m_pend == 0 && m_mode == MODE_IDLE); k++) begin
            krpt   = (m_mode == MODE_ASK);
            relpls = (m_mode == MODE_SERVE);
            step();
        end
        krpt = 0; relpls = 0;
        step();
    endtask

    task automatic test_reset();
        n_tests++;
        if ({pend, ruptor_n, rpt_idx, rpt_vec, rpt_stb, iip} !== {10'h0, 1'b1, 4'd0, 12'o4004, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got pend=%h ruptor_n=%b idx=%0d vec=%o stb=%b iip=%b want 000/1/0/4004/0/0",
                     pend, ruptor_n, rpt_idx, rpt_vec, rpt_stb, iip);
        end
    endtask

    task automatic test_single();
        rupt_req = 10'h008; step();
        n_tests++;
        if (pend !== 10'h008 || ruptor_n !== 1'b1) begin
            n_fail++; $display("FAIL single_pend: got pend=%h ruptor_n=%b want 008/1", pend, ruptor_n);
        end
        rupt_req = '0; step();
        n_tests++;
        if (ruptor_n !== 1'b0 || rpt_idx !== 4'd3) begin
            n_fail++; $display("FAIL single_ruptor: got ruptor_n=%b idx=%0d want 0/3", ruptor_n, rpt_idx);
        end
        krpt = 1; step(); krpt = 0;
        n_tests++;
        if ({rpt_stb, rpt_vec, iip, pend, ruptor_n} !== {1'b1, 12'o4020, 1'b1, 10'h0, 1'b1}) begin
            n_fail++; $display("FAIL single_krpt: got stb=%b vec=%o iip=%b pend=%h ruptor_n=%b want 1/4020/1/000/1",
                               rpt_stb, rpt_vec, iip, pend, ruptor_n);
        end
        step();
        n_tests++;
        if (rpt_stb !== 1'b0 || iip !== 1'b1) begin
            n_fail++; $display("FAIL single_stb_width: got stb=%b iip=%b want 0/1", rpt_stb, iip);
        end
        relpls = 1; step(); relpls = 0;
        n_tests++;
        if (iip !== 1'b0) begin
            n_fail++; $display("FAIL single_relpls: got iip=%b want 0", iip);
        end
        step();
    endtask

    task automatic test_multi();
        int          order[3]   = '{2, 7, 9};
        logic [11:0] vecs[3]    = '{12'o4014, 12'o4040, 12'o4050};
        logic [9:0]  remain[3]  = '{10'h280, 10'h200, 10'h000};
        rupt_req = 10'h284; step(); rupt_req = '0;
        for (int r = 0; r < 3; r++) begin
            int waited = 0;
            do begin step(); waited++; end while (ruptor_n !== 1'b0 && waited < 6);
            n_tests++;
            if (ruptor_n !== 1'b0 || rpt_idx !== 4'(order[r]) || rpt_vec !== vecs[r]) begin
                n_fail++; $display("FAIL multi_select%0d: got ruptor_n=%b idx=%0d vec=%o want 0/%0d/%o",
                                   r, ruptor_n, rpt_idx, rpt_vec, order[r], vecs[r]);
            end
            krpt = 1; step(); krpt = 0;
            n_tests++;
            if (rpt_stb !== 1'b1 || pend !== remain[r] || dut_obs() !== model_obs()) begin
                n_fail++; $display("FAIL multi_take%0d: got stb=%b pend=%h obs=%h want 1/%h model=%h",
                                   r, rpt_stb, pend, dut_obs(), remain[r], model_obs());
            end
            relpls = 1; step(); relpls = 0;
        end
        step();
    endtask

    task automatic test_inhint();
        inhint = 1;
        rupt_req = 10'h020; step(); rupt_req = '0;
        step(); step();
        n_tests++;
        if (pend !== 10'h020 || ruptor_n !== 1'b1) begin
            n_fail++; $display("FAIL inhint_hold: got pend=%h ruptor_n=%b want 020/1", pend, ruptor_n);
        end
        inhint = 0; step();
        n_tests++;
        if (ruptor_n !== 1'b0 || rpt_vec !== 12'o4030) begin
            n_fail++; $display("FAIL inhint_release: got ruptor_n=%b vec=%o want 0/4030", ruptor_n, rpt_vec);
        end
        drain();
    endtask

    task automatic test_extpnd_backoff();
        rupt_req = 10'h010; step(); rupt_req = '0; step();
        n_tests++;
        if (ruptor_n !== 1'b0 || rpt_idx !== 4'd4) begin
            n_fail++; $display("FAIL extpnd_req: got ruptor_n=%b idx=%0d want 0/4", ruptor_n, rpt_idx);
        end
        extpnd = 1; rupt_req = 10'h001; step(); rupt_req = '0;
        n_tests++;
        if (ruptor_n !== 1'b1 || pend !== 10'h011) begin
            n_fail++; $display("FAIL extpnd_backoff: got ruptor_n=%b pend=%h want 1/011", ruptor_n, pend);
        end
        step(); extpnd = 0; step();
        n_tests++;
        if (ruptor_n !== 1'b0 || rpt_idx !== 4'd0 || rpt_vec !== 12'o4004) begin
            n_fail++; $display("FAIL extpnd_rearb: got ruptor_n=%b idx=%0d vec=%o want 0/0/4004",
                               ruptor_n, rpt_idx, rpt_vec);
        end
        drain();
    endtask

    task automatic test_set_clear_collision();
        rupt_req = 10'h002; step(); rupt_req = '0; step();
        krpt = 1; rupt_req = 10'h002; step(); krpt = 0; rupt_req = '0;
        n_tests++;
        if (pend[1] !== 1'b1 || rpt_stb !== 1'b1 || iip !== 1'b1) begin
            n_fail++; $display("FAIL collision: got pend=%h stb=%b iip=%b want pend[1]=1 stb=1 iip=1",
                               pend, rpt_stb, iip);
        end
        drain();
    endtask

    task automatic test_held_high();
        inhint = 1; rupt_req = 10'h040;
        repeat (4) step();
        inhint = 0; step();
        krpt = 1; step(); krpt = 0;
        relpls = 1; step(); relpls = 0;
        repeat (3) step();
        n_tests++;
        if (pend !== 10'h000 || ruptor_n !== 1'b1 || iip !== 1'b0) begin
            n_fail++; $display("FAIL held_high: got pend=%h ruptor_n=%b iip=%b want 000/1/0", pend, ruptor_n, iip);
        end
        rupt_req = '0; step();
    endtask

    task automatic test_gojam();
        rupt_req = 10'h3FF; step(); rupt_req = '0; step();
        krpt = 1; step(); krpt = 0;
        rupt_req = 10'h001; step(); rupt_req = '0;
        n_tests++;
        if (pend !== 10'h3FF || iip !== 1'b1) begin
            n_fail++; $display("FAIL gojam_setup: got pend=%h iip=%b want 3ff/1", pend, iip);
        end
        gojam = 1; step(); gojam = 0;
        n_tests++;
        if ({pend, iip, ruptor_n, rpt_idx, rpt_vec} !== {10'h0, 1'b0, 1'b1, 4'd0, 12'o4004}) begin
            n_fail++; $display("FAIL gojam_clear: got pend=%h iip=%b ruptor_n=%b idx=%0d vec=%o want 000/0/1/0/4004",
                               pend, iip, ruptor_n, rpt_idx, rpt_vec);
        end
        step();
    endtask

    task automatic test_async_reset();
        rupt_req = 10'h004; step(); rupt_req = '0; step();
        n_tests++;
        if (ruptor_n !== 1'b0) begin
            n_fail++; $display("FAIL areset_setup: got ruptor_n=%b want 0", ruptor_n);
        end
        #2 sim_rst = 1'b0;
        #1;
        m_clear();
        n_tests++;
        if ({pend, ruptor_n, rpt_idx, rpt_stb, iip} !== {10'h0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL areset_immediate: got pend=%h ruptor_n=%b idx=%0d stb=%b iip=%b want 000/1/0/0/0",
                               pend, ruptor_n, rpt_idx, rpt_stb, iip);
        end
        @(posedge sim_clk); #1;
        sim_rst = 1'b1;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rupt_req = ($urandom_range(0, 5) == 0) ? (10'($urandom) & 10'($urandom)) : 10'h0;
            inhint   = ($urandom_range(0, 6) == 0);
            extpnd   = ($urandom_range(0, 12) == 0);
            ovnhrp   = ($urandom_range(0, 20) == 0);
            mnhrpt   = ($urandom_range(0, 30) == 0);
            krpt     = (m_mode == MODE_ASK) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 10) == 0);
            relpls   = (m_mode == MODE_SERVE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 10) == 0);
            gojam    = ($urandom_range(0, 250) == 0);
            step();
            n_tests++;
            if (dut_obs() !== model_obs()) begin
                n_fail++;
                $display("FAIL random_c%0d: got pend=%h ruptor_n=%b idx=%0d vec=%o stb=%b iip=%b model={pend,ruptor_n,idx,vec,stb,iip}=%h",
                         c, pend, ruptor_n, rpt_idx, rpt_vec, rpt_stb, iip, model_obs());
            end
        end
        {rupt_req, inhint, extpnd, ovnhrp, mnhrpt, krpt, relpls, gojam} = '0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_clear();
        repeat (2) @(posedge sim_clk);
        #1 sim_rst = 1'b1;
        test_reset();
        test_single();
        test_multi();
        test_inhint();
        test_extpnd_backoff();
        test_set_clear_collision();
        test_held_high();
        test_gojam();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
